// File: rtl/uart_frame_tx.sv
// uart_frame_tx: UART framer/serializer (start, 8 data LSB first, parity, stop); UART_TX_HOLD_EN adds a one-byte holding register
module uart_frame_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_serial,
   output logic       busy,
   output logic       done_flag
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    sh;
   logic          par;
   logic          accept, bit_end, frame_end, start_frame;
   logic [7:0]    start_byte;
   assign accept    = tx_start && tx_ready;
   assign bit_end   = (state != IDLE) && (cnt == CW'(CLKS_PER_BIT - 1));
   assign frame_end = bit_end && (state == STOP);
`ifdef UART_TX_HOLD_EN
   logic       hold_full;
   logic [7:0] hold_data;
   assign tx_ready    = ~hold_full;
   assign start_frame = (state == IDLE && accept) || (frame_end && (hold_full || accept));
   assign start_byte  = hold_full ? hold_data : tx_data;
   // park a byte accepted mid-frame; release it when the next frame starts from it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_full <= 1'b0;
         hold_data <= 8'h00;
      end else if (start_frame && hold_full) begin
         hold_full <= 1'b0;
      end else if (accept && !start_frame) begin
         hold_full <= 1'b1;
         hold_data <= tx_data;
      end
   end
`else
   assign start_frame = accept;
   assign start_byte  = tx_data;
   // ready only while idle: drops on acceptance, returns when the stop bit ends
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_ready <= 1'b1;
      else if (accept) tx_ready <= 1'b0;
      else if (frame_end) tx_ready <= 1'b1;
   end
`endif
   // frame sequencer: baud counter, bit walk through start/data/parity/stop, line driver
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= 3'd0;
         sh        <= 8'h00;
         par       <= 1'b0;
         tx_serial <= 1'b1;
         busy      <= 1'b0;
         done_flag <= 1'b0;
      end else begin
         done_flag <= frame_end;
         if (start_frame) begin
            state     <= START;
            cnt       <= '0;
            idx       <= 3'd0;
            sh        <= start_byte;
            par       <= PARITY_ODD ^ (^start_byte);
            tx_serial <= 1'b0;
            busy      <= 1'b1;
         end else if (state != IDLE) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (bit_end) begin
               case (state)
                  START: begin
                     state     <= DATA;
                     tx_serial <= sh[0];
                     sh        <= {1'b0, sh[7:1]};
                  end
                  DATA: begin
                     if (idx == 3'd7) begin
                        state     <= PARITY;
                        tx_serial <= par;
                     end else begin
                        tx_serial <= sh[0];
                        sh        <= {1'b0, sh[7:1]};
                        idx       <= idx + 3'd1;
                     end
                  end
                  PARITY: begin
                     state     <= STOP;
                     tx_serial <= 1'b1;
                  end
                  default: begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     tx_serial <= 1'b1;
                  end
               endcase
            end
         end
      end
   end
endmodule
